vg_wrpre: RTL



---
 rtl/vg_wrpre.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vg_wrpre.sv
// vg_wrpre: FDD write path for the WD1793 core. Each WD edge is delayed by a
// precompensation amount and then sent to the drive as a fixed-width
// active-low wdat_n pulse. One extra edge can be held while a pulse is busy.
//   fclk, rst_n            clock, async active-low reset
//   vg_wd, vg_wg           write-data strobe and write gate from the core (async)
//   vg_early, vg_late      precomp hints; vg_tr43 enables precomp
//   wdat_n, wg_n           active-low write data / write gate to the drive
//   busy                   a pulse is in delay/pulse/gap, or an edge is pending
//   overrun                sticky: an edge was dropped; cleared when the gate falls
module vg_wrpre #(
  parameter int unsigned PRECOMP   = 4,
  parameter int unsigned PULSE_LEN = 6
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic vg_wd,
  input  logic vg_wg,
  input  logic vg_early,
  input  logic vg_late,
  input  logic vg_tr43,
  output logic wdat_n,
  output logic wg_n,
  output logic busy,
  output logic overrun
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] D_NOM  = CW'(PRECOMP);
  localparam logic [CW-1:0] D_LATE = CW'(2 * PRECOMP);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;

  logic [4:0] sync1, sync2;
  logic wd_s, wg_s, early_s, late_s, tr43_s;
  logic wd_prev, wg_prev;

  state_t state, next_state;
  logic [CW-1:0] count, next_count;
  logic pend_v, next_pend_v;
  logic [CW-1:0] pend_d, next_pend_d;
  logic set_ovr;
  logic wd_edge, wg_fall;
  logic [CW-1:0] d_edge;
  logic do_load;
  logic [CW-1:0] load_d;

  // All five inputs share one synchronizer so the hints stay aligned with WD.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {vg_wd, vg_wg, vg_early, vg_late, vg_tr43};
      sync2 <= sync1;
    end
  end

  assign {wd_s, wg_s, early_s, late_s, tr43_s} = sync2;
  assign wd_edge = wd_s & ~wd_prev & wg_s;
  assign wg_fall = ~wg_s & wg_prev;

  // Precompensation delay for the edge seen this cycle.
  always_comb begin
    d_edge = D_NOM;
    if (tr43_s && early_s && !late_s) d_edge = '0;
    else if (tr43_s && late_s && !early_s) d_edge = D_LATE;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      pend_v  <= 1'b0;
      pend_d  <= '0;
      wd_prev <= 1'b0;
      wg_prev <= 1'b0;
      wdat_n  <= 1'b1;
      wg_n    <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      pend_v  <= next_pend_v;
      pend_d  <= next_pend_d;
      wd_prev <= wd_s;
      wg_prev <= wg_s;
      wdat_n  <= (state != PULSE);
      wg_n    <= ~wg_s;
      busy    <= (state != IDLE) | pend_v;
      if (wg_fall) overrun <= 1'b0;
      else if (set_ovr) overrun <= 1'b1;
    end
  end

  // Next state; do_load starts a new delay (or pulse when D is zero).
  always_comb begin
    next_state  = state;
    next_count  = count;
    next_pend_v = pend_v;
    next_pend_d = pend_d;
    set_ovr     = 1'b0;
    do_load     = 1'b0;
    load_d      = '0;
    if (!wg_s) begin
      next_state  = IDLE;
      next_count  = '0;
      next_pend_v = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wd_edge) begin
            do_load = 1'b1;
            load_d  = d_edge;
          end
        end
        DELAY, PULSE: begin
          if (count == '0) begin
            next_state = (state == DELAY) ? PULSE : GAP;
            next_count = (state == DELAY) ? P_LAST : '0;
          end else begin
            next_count = count - CW'(1);
          end
          if (wd_edge) begin
            if (pend_v) begin
              set_ovr = 1'b1;
            end else begin
              next_pend_v = 1'b1;
              next_pend_d = d_edge;
            end
          end
        end
        GAP: begin
          // The pending entry goes first; a simultaneous edge refills the slot.
          if (pend_v) begin
            do_load = 1'b1;
            load_d  = pend_d;
            if (wd_edge) begin
              next_pend_d = d_edge;
            end else begin
              next_pend_v = 1'b0;
            end
          end else if (wd_edge) begin
            do_load = 1'b1;
            load_d  = d_edge;
          end else begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
      if (do_load) begin
        if (load_d == '0) begin
          next_state = PULSE;
          next_count = P_LAST;
        end else begin
          next_state = DELAY;
          next_count = load_d - CW'(1);
        end
      end
    end
  end

endmodule
